fifo_reader: RTL and testbench

Read-side engine for the synchronous FIFO. It drains words through the FIFO's `rd_en`/`data_out`/`empty` port and presents them on a valid/ready stream with full throughput under backpressure. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency. The block also counts delivered words and latches FIFO underflow errors. It sits between the sync FIFO and any downstream consumer, and is the read-side counterpart of the stimulus writer.

---
 rtl/fifo_reader_pkg.sv | 12 +
 rtl/fifo_reader_skid.sv | 47 ++++
 rtl/fifo_reader.sv | 68 ++++++
 tb/tb_fifo_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side engine: default widths, the word type
// and the skid-buffer depth that the read-credit check is built around.
package fifo_reader_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int CNT_WIDTH  = 16;
   localparam int SKID_DEPTH = 2;
   localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

   typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: slot0 is the head word, slot1 catches the word that lands
// while the head is still waiting for the consumer.
module fifo_reader_skid #(
   parameter int WIDTH = fifo_reader_pkg::FIFO_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clear,
   input  logic                                  push,
   input  logic                                  pop,
   input  logic [WIDTH-1:0]                      din,
   output logic [WIDTH-1:0]                      head,
   output logic [fifo_reader_pkg::OCC_WIDTH-1:0] occ
);
   import fifo_reader_pkg::*;

   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             to_head;
   logic             shift;

   // A new word goes straight to the head when the head is free after this cycle's pop.
   assign to_head = (occ == OCC_WIDTH'(0)) || ((occ == OCC_WIDTH'(1)) && pop);
   assign shift   = pop && (occ == OCC_WIDTH'(SKID_DEPTH));
   assign head    = slot0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ   <= '0;
         slot0 <= '0;
         slot1 <= '0;
      end else if (clear) begin
         occ <= '0;
      end else begin
         if (push && to_head) begin
            slot0 <= din;
         end else if (shift) begin
            slot0 <= slot1;
         end
         if (push && !to_head) begin
            slot1 <= din;
         end
         occ <= occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
      end
   end

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for the sync FIFO: issues reads only when the skid buffer has room
// for every word already requested, and streams the result on a valid/ready port.
module fifo_reader #(
   parameter int FIFO_WIDTH = fifo_reader_pkg::FIFO_WIDTH,
   parameter int CNT_WIDTH  = fifo_reader_pkg::CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  err_underflow
);
   import fifo_reader_pkg::*;

   localparam logic [OCC_WIDTH:0] CREDIT_LIMIT = SKID_DEPTH[OCC_WIDTH:0];

   logic                 inflight_q;
   logic                 pop;
   logic                 push;
   logic [OCC_WIDTH-1:0] occ;
   logic [OCC_WIDTH:0]   credit_used;

   assign out_valid = (occ != '0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q & ~flush & ~fifo_underflow;

   // Slots that will be committed after this edge: buffered + in flight - leaving now.
   assign credit_used = {1'b0, occ} + (OCC_WIDTH + 1)'(inflight_q) - (OCC_WIDTH + 1)'(pop);
   assign fifo_rd_en  = ~rst & en & ~flush & ~fifo_empty & (credit_used < CREDIT_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q    <= 1'b0;
         rd_count      <= '0;
         err_underflow <= 1'b0;
      end else begin
         inflight_q <= fifo_rd_en;
         if (pop) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
         end
         if (inflight_q && fifo_underflow) begin
            err_underflow <= 1'b1;
         end
      end
   end

   fifo_reader_skid #(
      .WIDTH(FIFO_WIDTH)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .clear(flush),
      .push (push),
      .pop  (pop),
      .din  (fifo_data_out),
      .head (out_data),
      .occ  (occ)
   );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based FIFO model feeds the DUT, and a negedge
// scoreboard compares every delivered word, the counter and the error flag.
module tb_fifo_reader;

   localparam int W  = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          flush;
   logic          fifo_empty;
   logic [W-1:0]  fifo_data_out;
   logic          fifo_underflow;
   logic          fifo_rd_en;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] rd_count;
   logic          err_underflow;

   fifo_reader #(
      .FIFO_WIDTH(W),
      .CNT_WIDTH (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .flush         (flush),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_underflow(fifo_underflow),
      .fifo_rd_en    (fifo_rd_en),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .rd_count      (rd_count),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   int           fifo_wr_cnt = 0;
   int           fifo_rd_cnt = 0;
   int           exp_count = 0;
   bit           exp_err = 0;
   bit           rd_pending = 0;
   bit           rd_uf = 0;
   bit           uf_req = 0;
   logic [W-1:0] rd_word;
   bit           stall_prev = 0;
   logic [W-1:0] stall_data;

   assign fifo_empty = (fifo_wr_cnt == fifo_rd_cnt);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit en_v, input bit ready_v, input bit flush_v);
      en        = en_v;
      out_ready = ready_v;
      flush     = flush_v;
   endtask

   task automatic pushWord(input logic [W-1:0] w);
      fifo_q.push_back(w);
      fifo_wr_cnt++;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle(input int max_cycles);
      bit idle = 0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < max_cycles; i++) begin
         if (fifo_q.size() == 0 && !rd_pending && exp_q.size() == 0 && !out_valid) begin
            idle = 1;
            break;
         end
         nextCycle();
      end
      checkOutput("drain_within_budget", 32'(idle), 32'd1);
   endtask

   // FIFO model: a read taken in one cycle shows its data (and any forced underflow) in the next.
   always @(posedge clk) begin
      if (rd_pending) begin
         fifo_data_out <= rd_word;
         fifo_rd_cnt   <= fifo_rd_cnt + 1;
      end
      fifo_underflow <= rd_pending & rd_uf;
   end

   // Scoreboard: the expected stream is every word read from the FIFO, minus flushed
   // and underflowed ones, in read order.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
         checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
         checkOutput("rst_out_data", 32'(out_data), 32'd0);
         checkOutput("rst_rd_count", 32'(rd_count), 32'd0);
         checkOutput("rst_err", 32'(err_underflow), 32'd0);
         exp_q.delete();
         exp_count  = 0;
         exp_err    = 0;
         rd_pending = 0;
         rd_uf      = 0;
         stall_prev = 0;
      end else begin
         checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         checkOutput("rd_count", 32'(rd_count), 32'(exp_count % (1 << CW)));
         checkOutput("err_underflow", 32'(err_underflow), 32'(exp_err));
         if (stall_prev) begin
            checkOutput("stall_valid_hold", 32'(out_valid), 32'd1);
            checkOutput("stall_data_hold", 32'(out_data), 32'(stall_data));
         end
         if (fifo_rd_en) begin
            checkOutput("rd_en_legal", 32'(en & ~flush & ~fifo_empty), 32'd1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("pop_unexpected", 32'(out_valid), 32'd0);
            end else begin
               checkOutput("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            exp_count++;
         end
         stall_prev = out_valid & ~out_ready & ~flush;
         stall_data = out_data;
         if (flush) begin
            exp_q.delete();
         end
         if (rd_pending) begin
            if (rd_uf) begin
               exp_err = 1;
            end else if (!flush) begin
               exp_q.push_back(rd_word);
            end
         end
         rd_pending = fifo_rd_en;
         rd_uf      = 0;
         if (fifo_rd_en) begin
            rd_word = (fifo_q.size() != 0) ? fifo_q.pop_front() : 'x;
            rd_uf   = uf_req;
            uf_req  = 0;
         end
         checkOutput("occ_bound", 32'((exp_q.size() + int'(rd_pending)) <= 2), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int           first_rd;
      int           first_v;
      int           last_pop;
      int           npop;
      logic [W-1:0] hold;
      logic [CW-1:0] cnt_before;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) pushWord(W'(i));
      repeat (5) begin
         @(posedge clk);
         #3;
         checkOutput("rst_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      end

      // Streaming straight out of reset
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      first_rd = -1;
      first_v  = -1;
      last_pop = -1;
      npop     = 0;
      for (int i = 0; i < 40 && npop < 16; i++) begin
         #2;
         if (i == 0) checkOutput("first_read_after_reset", 32'(fifo_rd_en), 32'd1);
         if (fifo_rd_en && first_rd < 0) first_rd = i;
         if (out_valid && first_v < 0) first_v = i;
         if (out_valid && out_ready) begin
            npop++;
            last_pop = i;
         end
         nextCycle();
      end
      checkOutput("stream_words", 32'(npop), 32'd16);
      checkOutput("stream_latency", 32'(first_v - first_rd), 32'd2);
      checkOutput("stream_back_to_back", 32'(last_pop - first_v), 32'd15);
      pushWord(16'h0011);
      waitIdle(30);
      checkOutput("count_wrap_17", 32'(rd_count), 32'd1);

      // Backpressure, resume, then flush with both slots full
      for (int i = 0; i < 24; i++) pushWord(16'h0100 + W'(i));
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (6) nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      hold = '0;
      for (int k = 0; k < 4; k++) begin
         #2;
         checkOutput("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
         if (k == 0) begin
            hold = out_data;
         end else begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_data_stable", 32'(out_data), 32'(hold));
         end
         nextCycle();
      end
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (6) nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (2) nextCycle();
      #2;
      hold       = out_data;
      cnt_before = rd_count;
      applyStimulus(1'b1, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0);
      #2;
      checkOutput("flush_valid_low", 32'(out_valid), 32'd0);
      checkOutput("flush_count_kept", 32'(rd_count), 32'(cnt_before));
      for (int i = 0; i < 10 && !out_valid; i++) begin
         nextCycle();
         #2;
      end
      checkOutput("flush_next_word", 32'(out_data), 32'(W'(hold + W'(2))));
      waitIdle(60);

      // Underflow: one word dropped, sticky through a flush
      cnt_before = rd_count;
      for (int i = 0; i < 8; i++) pushWord(16'h0200 + W'(i));
      applyStimulus(1'b1, 1'b1, 1'b0);
      nextCycle();
      uf_req = 1;
      waitIdle(40);
      checkOutput("uf_err_set", 32'(err_underflow), 32'd1);
      checkOutput("uf_word_dropped", 32'(rd_count), 32'(CW'(cnt_before + CW'(7))));
      applyStimulus(1'b1, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0);
      #2;
      checkOutput("uf_err_after_flush", 32'(err_underflow), 32'd1);

      // Asynchronous reset in the middle of a transfer
      for (int i = 0; i < 10; i++) pushWord(16'h0300 + W'(i));
      repeat (3) nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_count", 32'(rd_count), 32'd0);
      checkOutput("async_rst_err", 32'(err_underflow), 32'd0);
      checkOutput("async_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      repeat (2) nextCycle();
      rst = 1'b0;
      waitIdle(60);

      // Randomized traffic against the scoreboard
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) pushWord(W'($urandom));
         if ($urandom_range(0, 39) == 0) uf_req = 1;
         nextCycle();
      end
      waitIdle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
